// File: rtl/seq_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | seq_pkg : shared constants, step actions and clog2 helper          |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
package seq_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_UP   = 2'd2,
    ACT_DOWN = 2'd3
  } step_act_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/moore_step_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | moore_step_sequencer : N-state up/down Moore step sequencer        |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module moore_step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int WRAP_TO    = 1,
  parameter int SATURATE   = 0,
  parameter int OUT_W      = 3,
  localparam int IDX_W     = (clog2(NUM_STATES) > 1) ? clog2(NUM_STATES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             dir,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  output logic [OUT_W-1:0] out,
  output logic             at_first,
  output logic             at_last,
  output logic             wrapped
);

  // One extra bit so NUM_STATES itself is representable for range checks.
  localparam logic [IDX_W:0]   NUM_EXT  = NUM_STATES[IDX_W:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STATES - 1);
  localparam logic [IDX_W-1:0] WRAP_IDX = IDX_W'(WRAP_TO);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_chk_num_states
    $error("moore_step_sequencer: NUM_STATES must be in 2..256");
  end
  if (WRAP_TO < 0 || WRAP_TO >= NUM_STATES) begin : g_chk_wrap_to
    $error("moore_step_sequencer: WRAP_TO must be in 0..NUM_STATES-1");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_chk_saturate
    $error("moore_step_sequencer: SATURATE must be 0 or 1");
  end
  if (OUT_W < 1 || OUT_W > 30 || (1 << OUT_W) <= NUM_STATES) begin : g_chk_out_w
    $error("moore_step_sequencer: OUT_W too narrow for NUM_STATES");
  end

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             wrapped_nxt;
  logic             idx_legal;
  logic             load_ok;
  logic [IDX_W:0]   idx_plus1;
  step_act_t        act;

  assign idx_legal = ({1'b0, idx} < NUM_EXT);
  assign load_ok   = ({1'b0, load_val} < NUM_EXT);

  always_comb begin
    act = ACT_HOLD;
    if (load) begin
      act = ACT_LOAD;
    end else if (in) begin
      act = (dir == DIR_UP) ? ACT_UP : ACT_DOWN;
    end
  end

  always_comb begin
    idx_nxt     = idx;
    wrapped_nxt = 1'b0;
    unique case (act)
      ACT_LOAD: begin
        if (load_ok) idx_nxt = load_val;
      end
      ACT_UP: begin
        if (!idx_legal) begin
          idx_nxt = '0;
        end else if (idx == LAST_IDX) begin
          if (SATURATE == MODE_WRAP) begin
            idx_nxt     = WRAP_IDX;
            wrapped_nxt = 1'b1;
          end
        end else begin
          idx_nxt = idx + ONE_IDX;
        end
      end
      ACT_DOWN: begin
        if (!idx_legal) begin
          idx_nxt = '0;
        end else if (idx == '0) begin
          if (SATURATE == MODE_WRAP) begin
            idx_nxt     = LAST_IDX;
            wrapped_nxt = 1'b1;
          end
        end else begin
          idx_nxt = idx - ONE_IDX;
        end
      end
      default: begin
        idx_nxt     = idx;
        wrapped_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx     <= '0;
      wrapped <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  // Illegal indices never match 0 or LAST_IDX, so both flags drop for them.
  assign at_first  = (idx == '0);
  assign at_last   = (idx == LAST_IDX);
  assign idx_plus1 = {1'b0, idx} + (IDX_W + 1)'(1);

  if (OUT_W > IDX_W + 1) begin : g_out_ext
    assign out = {{(OUT_W - IDX_W - 1){1'b0}}, idx_plus1};
  end else if (OUT_W == IDX_W + 1) begin : g_out_exact
    assign out = idx_plus1;
  end else begin : g_out_trunc
    assign out = idx_plus1[OUT_W-1:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_moore_step_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_moore_step_sequencer : directed self-checking bench             |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module tb_moore_step_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in    = 1'b0;
  logic       dir   = 1'b1;
  logic       load  = 1'b0;
  logic [2:0] lv    = 3'd0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  logic [2:0] def_out, sat_out, n6_out;
  logic [1:0] n3_out, n2_out;
  logic def_first, def_last, def_wr;
  logic sat_first, sat_last, sat_wr;
  logic n3_first, n3_last, n3_wr;
  logic n6_first, n6_last, n6_wr;
  logic n2_first, n2_last, n2_wr;

  moore_step_sequencer u_def (
    .clock(clock), .reset(reset), .in(in), .dir(dir), .load(load), .load_val(lv[1:0]),
    .out(def_out), .at_first(def_first), .at_last(def_last), .wrapped(def_wr));

  moore_step_sequencer #(.SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .in(in), .dir(dir), .load(load), .load_val(lv[1:0]),
    .out(sat_out), .at_first(sat_first), .at_last(sat_last), .wrapped(sat_wr));

  moore_step_sequencer #(.NUM_STATES(3), .WRAP_TO(1), .OUT_W(2)) u_n3 (
    .clock(clock), .reset(reset), .in(in), .dir(dir), .load(load), .load_val(lv[1:0]),
    .out(n3_out), .at_first(n3_first), .at_last(n3_last), .wrapped(n3_wr));

  moore_step_sequencer #(.NUM_STATES(6), .WRAP_TO(0), .OUT_W(3)) u_n6 (
    .clock(clock), .reset(reset), .in(in), .dir(dir), .load(load), .load_val(lv),
    .out(n6_out), .at_first(n6_first), .at_last(n6_last), .wrapped(n6_wr));

  moore_step_sequencer #(.NUM_STATES(2), .WRAP_TO(1), .OUT_W(2)) u_n2 (
    .clock(clock), .reset(reset), .in(in), .dir(dir), .load(load), .load_val(lv[0]),
    .out(n2_out), .at_first(n2_first), .at_last(n2_last), .wrapped(n2_wr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in    = 1'b0;
    load  = 1'b0;
    dir   = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int exp_up[6]  = '{2, 3, 4, 2, 3, 4};
  int exp_upw[6] = '{0, 0, 0, 1, 0, 0};
  int exp_dn[4]  = '{2, 1, 4, 3};
  int exp_dnw[4] = '{0, 0, 1, 0};
  int exp_s_up[5] = '{2, 3, 4, 4, 4};
  int exp_s_dn[5] = '{3, 2, 1, 1, 1};
  int exp_n6[7]  = '{2, 3, 4, 5, 6, 1, 2};
  int exp_n6w[7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and continuous up-stepping in wrap mode
    do_reset();
    check("rst_out", def_out, 1);
    check("rst_first", def_first, 1);
    check("rst_last", def_last, 0);
    check("rst_wrapped", def_wr, 0);
    in = 1'b1; dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("up_out[%0d]", i), def_out, exp_up[i]);
      check($sformatf("up_wr[%0d]", i), def_wr, exp_upw[i]);
      check($sformatf("up_last[%0d]", i), def_last, (exp_up[i] == 4) ? 1 : 0);
    end

    // Hold, then down-stepping with wrap at the bottom
    do_reset();
    in = 1'b1; dir = 1'b1;
    tick(); tick();
    check("pre_hold_out", def_out, 3);
    in = 1'b0; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_out[%0d]", i), def_out, 3);
      check($sformatf("hold_wr[%0d]", i), def_wr, 0);
    end
    in = 1'b1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("dn_out[%0d]", i), def_out, exp_dn[i]);
      check($sformatf("dn_wr[%0d]", i), def_wr, exp_dnw[i]);
    end

    // Saturate mode at both ends
    do_reset();
    in = 1'b1; dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_up_out[%0d]", i), sat_out, exp_s_up[i]);
      check($sformatf("sat_up_wr[%0d]", i), sat_wr, 0);
    end
    check("sat_at_last", sat_last, 1);
    dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_dn_out[%0d]", i), sat_out, exp_s_dn[i]);
      check($sformatf("sat_dn_wr[%0d]", i), sat_wr, 0);
    end
    check("sat_at_first", sat_first, 1);

    // Load beats step, load never pulses wrapped
    do_reset();
    in = 1'b1; dir = 1'b1;
    tick();
    check("ld_pre_out", def_out, 2);
    load = 1'b1; lv = 3'd3;
    tick();
    check("ld_out", def_out, 4);
    check("ld_wr", def_wr, 0);
    check("ld_last", def_last, 1);
    load = 1'b0; in = 1'b0;

    // Out-of-range load ignored at NUM_STATES=3, legal load accepted
    do_reset();
    in = 1'b1; dir = 1'b1;
    tick();
    check("n3_pre_out", n3_out, 2);
    in = 1'b0; load = 1'b1; lv = 3'd3;
    tick();
    check("n3_bad_ld_out", n3_out, 2);
    lv = 3'd2;
    tick();
    check("n3_ld_out", n3_out, 3);
    check("n3_ld_last", n3_last, 1);
    load = 1'b0;

    // Reset only acts at the clock edge and beats load/step
    do_reset();
    in = 1'b1; dir = 1'b1;
    tick(); tick();
    check("rs_pre_out", def_out, 3);
    reset = 1'b1; load = 1'b1; lv = 3'd3;
    #3;
    check("rs_between_edges", def_out, 3);
    tick();
    check("rs_out", def_out, 1);
    check("rs_wr", def_wr, 0);
    check("rs_first", def_first, 1);
    reset = 1'b0; load = 1'b0; in = 1'b0;

    // Non-power-of-two sequence with WRAP_TO=0
    do_reset();
    check("n6_rst_out", n6_out, 1);
    in = 1'b1; dir = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("n6_out[%0d]", i), n6_out, exp_n6[i]);
      check($sformatf("n6_wr[%0d]", i), n6_wr, exp_n6w[i]);
    end

    // Two states, WRAP_TO=1: wrapping every cycle gives back-to-back pulses
    do_reset();
    in = 1'b1; dir = 1'b1;
    tick();
    check("n2_out0", n2_out, 2);
    check("n2_wr0", n2_wr, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("n2_out[%0d]", i), n2_out, 2);
      check($sformatf("n2_wr[%0d]", i), n2_wr, 1);
    end
    in = 1'b0;
    tick();
    check("n2_idle_wr", n2_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
